avalon_mm_hex_display_master: RTL

- Avalon-MM master that drives the seven-segment PIO output slaves (one 32-bit PIO per digit) from a single hex value.
- Accepts a value on a valid/ready input and splits it into nibbles. Each nibble is encoded to an active-low 7-segment pattern and written to that digit's PIO data register in sequence, honouring waitrequest.
- Sits between control logic (CPU-side or FSM) and the system interconnect. It is the initiator counterpart of the PIO write slaves.

---
 rtl/avalon_mm_hex_display_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/avalon_mm_hex_display_master.sv
// Avalon-MM master writing 7-seg codes of a hex value to per-digit PIOs.
// Optional readback verify: define HEX_DISPLAY_READBACK_EN.
module avalon_mm_hex_display_master #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] STRIDE     = 32'h0000_0010
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  output logic                    busy,
  output logic                    done,
  output logic                    verify_err,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic                    avm_read,
  output logic [3:0]              avm_byteenable,
  output logic [31:0]             avm_writedata,
  input  logic [31:0]             avm_readdata,
  input  logic                    avm_waitrequest
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned IW = 3;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STR  = ADDR_W'(STRIDE);

`ifdef HEX_DISPLAY_READBACK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd3
  } state_e;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     val_q, val_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        nib;

`ifdef HEX_DISPLAY_READBACK_EN
  logic err_q, err_d;
  logic unused_rd;
  assign unused_rd = ^avm_readdata[31:7];
`else
  logic unused_rd;
  assign unused_rd = ^avm_readdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      addr_q  <= BASE;
      wdata_q <= '0;
`ifdef HEX_DISPLAY_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef HEX_DISPLAY_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nib     = 4'h0;
`ifdef HEX_DISPLAY_READBACK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_WRITE;
          val_d   = in_value;
          idx_d   = '0;
`ifdef HEX_DISPLAY_READBACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
`ifdef HEX_DISPLAY_READBACK_EN
          state_d = S_READ;
`else
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
`endif
        end
      end
`ifdef HEX_DISPLAY_READBACK_EN
      S_READ: begin
        if (!avm_waitrequest) begin
          if (avm_readdata[6:0] != wdata_q[6:0]) begin
            err_d = 1'b1;
          end
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Recomputed from held idx/value, so stable while stalled.
    if (state_d == S_WRITE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IW'(i)) nib = val_d[4*i +: 4];
      end
      addr_d  = BASE + (ADDR_W'(idx_d) * STR);
      wdata_d = {25'b0, seg7(nib)};
    end
  end

  always_comb begin
    avm_write = 1'b0;
    avm_read  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = reset_n;
      end
      S_WRITE: avm_write = 1'b1;
`ifdef HEX_DISPLAY_READBACK_EN
      S_READ:  avm_read  = 1'b1;
`endif
      S_DONE:  done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'b1111;
`ifdef HEX_DISPLAY_READBACK_EN
  assign verify_err     = err_q;
`else
  assign verify_err     = 1'b0;
`endif

endmodule
